// File: rtl/axi_mem_read_arbiter_pkg.sv
// Shared types and AXI constants for the two-requester memory read arbiter.
package axi_mem_read_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_RESP
  } state_t;

  typedef enum logic {
    REQ_IFU = 1'b0,
    REQ_LSU = 1'b1
  } req_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [2:0] IFU_ARSIZE  = 3'b010;

endpackage

// File: rtl/axi_mem_read_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: remembers the last served requester and
// favours the other one when both ask at once.
module mem_rr_arb2
  import axi_mem_read_arbiter_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req_ifu,
  input  logic req_lsu,
  input  logic update,
  input  req_t served,
  output logic grant_valid,
  output req_t grant
);

  req_t last_grant;

  always_ff @(posedge clk) begin
    if (!rst) begin
      last_grant <= REQ_IFU;
    end else if (update) begin
      last_grant <= served;
    end
  end

  always_comb begin
    grant_valid = req_ifu | req_lsu;
    grant       = REQ_IFU;
    if (req_ifu && req_lsu) begin
      grant = (last_grant == REQ_IFU) ? REQ_LSU : REQ_IFU;
    end else if (req_lsu) begin
      grant = REQ_LSU;
    end
  end

endmodule

// File: rtl/axi_mem_read_arbiter.sv
// Shares the memory slave's AXI4 read port between IFU and LSU, one
// single-beat read in flight at a time, with a registered response.
module axi_mem_read_arbiter
  import axi_mem_read_arbiter_pkg::*;
#(
  parameter int              ADDR_W = 32,
  parameter int              DATA_W = 64,
  parameter int              ID_W   = 4,
  parameter logic [ID_W-1:0] IFU_ID = 4'd0,
  parameter logic [ID_W-1:0] LSU_ID = 4'd1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ifu_arvalid,
  output logic              ifu_arready,
  input  logic [ADDR_W-1:0] ifu_araddr,
  output logic              ifu_rvalid,
  input  logic              ifu_rready,
  output logic [DATA_W-1:0] ifu_rdata,
  output logic [1:0]        ifu_rresp,
  input  logic              lsu_arvalid,
  output logic              lsu_arready,
  input  logic [ADDR_W-1:0] lsu_araddr,
  input  logic [2:0]        lsu_arsize,
  output logic              lsu_rvalid,
  input  logic              lsu_rready,
  output logic [DATA_W-1:0] lsu_rdata,
  output logic [1:0]        lsu_rresp,
  output logic              io_master_arvalid,
  input  logic              io_master_arready,
  output logic [ADDR_W-1:0] io_master_araddr,
  output logic [ID_W-1:0]   io_master_arid,
  output logic [7:0]        io_master_arlen,
  output logic [2:0]        io_master_arsize,
  output logic [1:0]        io_master_arburst,
  input  logic              io_master_rvalid,
  output logic              io_master_rready,
  input  logic [DATA_W-1:0] io_master_rdata,
  input  logic [1:0]        io_master_rresp,
  input  logic              io_master_rlast,
  input  logic [ID_W-1:0]   io_master_rid
);

  state_t             state;
  req_t               sel_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [2:0]         size_q;
  logic [ID_W-1:0]    id_q;
  logic [DATA_W-1:0]  rdata_q;
  logic [1:0]         rresp_q;
  logic               arvalid_q;
  logic               rready_q;
  logic               ifu_rvalid_q;
  logic               lsu_rvalid_q;
  logic               grant_valid;
  req_t               grant;
  logic               resp_fire;
  logic               unused_rlast;

  // Every transfer is a single beat, so rlast carries no information.
  assign unused_rlast = io_master_rlast;

  assign resp_fire = (state == ST_RESP) &&
                     ((sel_q == REQ_IFU) ? ifu_rready : lsu_rready);

  mem_rr_arb2 u_arb (
    .clk         (clk),
    .rst         (rst),
    .req_ifu     (ifu_arvalid && (state == ST_IDLE)),
    .req_lsu     (lsu_arvalid && (state == ST_IDLE)),
    .update      (resp_fire),
    .served      (sel_q),
    .grant_valid (grant_valid),
    .grant       (grant)
  );

  assign ifu_arready = grant_valid && (grant == REQ_IFU);
  assign lsu_arready = grant_valid && (grant == REQ_LSU);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= ST_IDLE;
      sel_q        <= REQ_IFU;
      addr_q       <= '0;
      size_q       <= '0;
      id_q         <= '0;
      rdata_q      <= '0;
      rresp_q      <= '0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      ifu_rvalid_q <= 1'b0;
      lsu_rvalid_q <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (grant_valid) begin
            state     <= ST_ADDR;
            arvalid_q <= 1'b1;
            sel_q     <= grant;
            if (grant == REQ_LSU) begin
              addr_q <= lsu_araddr;
              size_q <= lsu_arsize;
              id_q   <= LSU_ID;
            end else begin
              addr_q <= ifu_araddr;
              size_q <= IFU_ARSIZE;
              id_q   <= IFU_ID;
            end
          end
        end
        ST_ADDR: begin
          if (io_master_arready) begin
            state     <= ST_DATA;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
          end
        end
        ST_DATA: begin
          if (io_master_rvalid) begin
            state        <= ST_RESP;
            rready_q     <= 1'b0;
            rdata_q      <= io_master_rdata;
            // A stray ID means the slave answered someone else; flag it.
            rresp_q      <= (io_master_rid == id_q) ? io_master_rresp : RESP_SLVERR;
            ifu_rvalid_q <= (sel_q == REQ_IFU);
            lsu_rvalid_q <= (sel_q == REQ_LSU);
          end
        end
        ST_RESP: begin
          if (resp_fire) begin
            state        <= ST_IDLE;
            ifu_rvalid_q <= 1'b0;
            lsu_rvalid_q <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign io_master_arvalid = arvalid_q;
  assign io_master_araddr  = addr_q;
  assign io_master_arid    = id_q;
  assign io_master_arsize  = size_q;
  assign io_master_arlen   = 8'd0;
  assign io_master_arburst = BURST_INCR;
  assign io_master_rready  = rready_q;
  assign ifu_rvalid        = ifu_rvalid_q;
  assign lsu_rvalid        = lsu_rvalid_q;
  assign ifu_rdata         = rdata_q;
  assign lsu_rdata         = rdata_q;
  assign ifu_rresp         = rresp_q;
  assign lsu_rresp         = rresp_q;

endmodule

// File: tb/tb_axi_mem_read_arbiter.sv
// Randomized self-checking bench: the bench plays both requesters and the
// memory slave, predicting grants and responses from a transaction-level model.
module tb_axi_mem_read_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_arvalid, ifu_arready, ifu_rvalid, ifu_rready;
  logic [31:0] ifu_araddr;
  logic [63:0] ifu_rdata;
  logic [1:0]  ifu_rresp;
  logic        lsu_arvalid, lsu_arready, lsu_rvalid, lsu_rready;
  logic [31:0] lsu_araddr;
  logic [2:0]  lsu_arsize;
  logic [63:0] lsu_rdata;
  logic [1:0]  lsu_rresp;
  logic        io_master_arvalid, io_master_arready;
  logic [31:0] io_master_araddr;
  logic [3:0]  io_master_arid;
  logic [7:0]  io_master_arlen;
  logic [2:0]  io_master_arsize;
  logic [1:0]  io_master_arburst;
  logic        io_master_rvalid, io_master_rready, io_master_rlast;
  logic [63:0] io_master_rdata;
  logic [1:0]  io_master_rresp;
  logic [3:0]  io_master_rid;

  int n_cmp = 0;
  int n_bad = 0;

  // Transaction-level model: pending requests and who was served last.
  bit          pend_ifu, pend_lsu, last_lsu;
  logic [31:0] addr_ifu, addr_lsu;
  logic [2:0]  size_lsu;

  axi_mem_read_arbiter dut (
    .clk(clk), .rst(rst),
    .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready), .ifu_araddr(ifu_araddr),
    .ifu_rvalid(ifu_rvalid), .ifu_rready(ifu_rready), .ifu_rdata(ifu_rdata), .ifu_rresp(ifu_rresp),
    .lsu_arvalid(lsu_arvalid), .lsu_arready(lsu_arready), .lsu_araddr(lsu_araddr),
    .lsu_arsize(lsu_arsize), .lsu_rvalid(lsu_rvalid), .lsu_rready(lsu_rready),
    .lsu_rdata(lsu_rdata), .lsu_rresp(lsu_rresp),
    .io_master_arvalid(io_master_arvalid), .io_master_arready(io_master_arready),
    .io_master_araddr(io_master_araddr), .io_master_arid(io_master_arid),
    .io_master_arlen(io_master_arlen), .io_master_arsize(io_master_arsize),
    .io_master_arburst(io_master_arburst), .io_master_rvalid(io_master_rvalid),
    .io_master_rready(io_master_rready), .io_master_rdata(io_master_rdata),
    .io_master_rresp(io_master_rresp), .io_master_rlast(io_master_rlast),
    .io_master_rid(io_master_rid)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic raiseIfu(input logic [31:0] a);
    if (!pend_ifu) begin
      pend_ifu = 1'b1; addr_ifu = a;
      ifu_arvalid = 1'b1; ifu_araddr = a;
    end
  endtask

  task automatic raiseLsu(input logic [31:0] a, input logic [2:0] s);
    if (!pend_lsu) begin
      pend_lsu = 1'b1; addr_lsu = a; size_lsu = s;
      lsu_arvalid = 1'b1; lsu_araddr = a; lsu_arsize = s;
    end
  endtask

  // Serves one request end to end; entered and left at posedge+1 in IDLE.
  task automatic applyStimulus(input int ar_stall, input int r_stall, input int hold,
                               input bit bad_rid, input logic [63:0] data,
                               input logic [1:0] resp);
    bit          g;
    logic [31:0] ea;
    logic [2:0]  es;
    logic [3:0]  eid;
    logic [1:0]  er;
    g   = (pend_ifu && pend_lsu) ? !last_lsu : pend_lsu;
    ea  = g ? addr_lsu : addr_ifu;
    es  = g ? size_lsu : 3'b010;
    eid = g ? 4'd1 : 4'd0;
    er  = bad_rid ? 2'b10 : resp;
    @(negedge clk);
    checkOutput("ifu_arready", ifu_arready, !g);
    checkOutput("lsu_arready", lsu_arready, g);
    checkOutput("idle_arvalid", io_master_arvalid, 0);
    nextCycle();
    if (g) begin pend_lsu = 0; lsu_arvalid = 0; lsu_araddr = $urandom; end
    else   begin pend_ifu = 0; ifu_arvalid = 0; ifu_araddr = $urandom; end
    if ($urandom_range(0, 2) == 0) begin
      if (g) raiseIfu($urandom);
      else   raiseLsu($urandom, 3'($urandom_range(0, 3)));
    end
    for (int i = 0; i <= ar_stall; i++) begin
      io_master_arready = (i == ar_stall);
      @(negedge clk);
      checkOutput("arvalid", io_master_arvalid, 1);
      checkOutput("araddr", io_master_araddr, ea);
      checkOutput("arid", io_master_arid, eid);
      checkOutput("arsize", io_master_arsize, es);
      checkOutput("arlen_burst", {io_master_arlen, io_master_arburst}, {8'd0, 2'b01});
      checkOutput("addr_busy", {ifu_arready, lsu_arready, io_master_rready}, 0);
      nextCycle();
    end
    io_master_arready = 1'b0;
    for (int i = 0; i <= r_stall; i++) begin
      io_master_rvalid = (i == r_stall);
      io_master_rdata  = (i == r_stall) ? data : {$urandom, $urandom};
      io_master_rid    = bad_rid ? 4'd7 : eid;
      io_master_rresp  = resp;
      @(negedge clk);
      checkOutput("rready", io_master_rready, 1);
      checkOutput("data_busy", {io_master_arvalid, ifu_rvalid, lsu_rvalid, ifu_arready, lsu_arready}, 0);
      nextCycle();
    end
    io_master_rvalid = 1'b0;
    io_master_rdata  = {$urandom, $urandom};
    io_master_rid    = 4'($urandom);
    io_master_rresp  = 2'($urandom);
    for (int i = 0; i <= hold; i++) begin
      if (g) begin lsu_rready = (i == hold); ifu_rready = 1'($urandom); end
      else   begin ifu_rready = (i == hold); lsu_rready = 1'($urandom); end
      @(negedge clk);
      checkOutput("ifu_rvalid", ifu_rvalid, !g);
      checkOutput("lsu_rvalid", lsu_rvalid, g);
      checkOutput("ifu_rdata", ifu_rdata, data);
      checkOutput("lsu_rdata", lsu_rdata, data);
      checkOutput("rresp", {ifu_rresp, lsu_rresp}, {er, er});
      checkOutput("resp_busy", {ifu_arready, lsu_arready, io_master_rready, io_master_arvalid}, 0);
      nextCycle();
    end
    ifu_rready = 1'b0;
    lsu_rready = 1'b0;
    last_lsu   = g;
    checkOutput("rvalid_once", {ifu_rvalid, lsu_rvalid}, 0);
  endtask

  task automatic drain();
    while (pend_ifu || pend_lsu) applyStimulus(0, 0, 0, 0, {$urandom, $urandom}, 2'b00);
  endtask

  initial begin
    rst = 1'b0;
    ifu_arvalid = 0; ifu_araddr = 0; ifu_rready = 0;
    lsu_arvalid = 0; lsu_araddr = 0; lsu_arsize = 0; lsu_rready = 0;
    io_master_arready = 0; io_master_rvalid = 0; io_master_rdata = 0;
    io_master_rresp = 0; io_master_rlast = 1; io_master_rid = 0;
    pend_ifu = 0; pend_lsu = 0; last_lsu = 0;
    repeat (3) nextCycle();
    @(negedge clk);
    checkOutput("reset_valids", {io_master_arvalid, io_master_rready, ifu_rvalid, lsu_rvalid,
                                 ifu_arready, lsu_arready}, 0);
    checkOutput("reset_ar", {io_master_araddr, io_master_arid, io_master_arsize}, 0);
    checkOutput("reset_rdata", ifu_rdata, 0);
    nextCycle();
    rst = 1'b1;
    nextCycle();

    raiseIfu(32'h8000_0000);
    applyStimulus(0, 0, 0, 0, 64'h1122_3344_5566_7788, 2'b00);

    // Simultaneous requests alternate LSU, IFU, LSU, IFU.
    for (int k = 0; k < 4; k++) begin
      raiseIfu($urandom);
      raiseLsu($urandom, 3'($urandom_range(0, 3)));
      applyStimulus(0, 0, 0, 0, {$urandom, $urandom}, 2'b00);
    end
    drain();

    raiseIfu($urandom);
    applyStimulus(5, 3, 0, 0, {$urandom, $urandom}, 2'b00);
    drain();

    raiseLsu($urandom, 3'd3);
    applyStimulus(0, 0, 0, 1, 64'hDEAD_BEEF_0BAD_F00D, 2'b00);
    drain();

    raiseIfu($urandom);
    raiseLsu($urandom, 3'd1);
    applyStimulus(0, 0, 4, 0, {$urandom, $urandom}, 2'b01);
    applyStimulus(0, 0, 0, 0, {$urandom, $urandom}, 2'b00);
    drain();

    // Reset while waiting for read data: transfer is dropped silently.
    raiseIfu($urandom);
    @(negedge clk);
    checkOutput("rst_seq_arready", ifu_arready, 1);
    nextCycle();
    ifu_arvalid = 0; pend_ifu = 0; io_master_arready = 1;
    @(negedge clk);
    checkOutput("rst_seq_arvalid", io_master_arvalid, 1);
    nextCycle();
    io_master_arready = 0;
    @(negedge clk);
    checkOutput("rst_seq_rready", io_master_rready, 1);
    nextCycle();
    rst = 1'b0; io_master_rvalid = 1; io_master_rid = 0;
    nextCycle();
    rst = 1'b1; io_master_rvalid = 0;
    last_lsu = 0;
    @(negedge clk);
    checkOutput("midrst_valids", {io_master_arvalid, io_master_rready, ifu_rvalid, lsu_rvalid,
                                  ifu_arready, lsu_arready}, 0);
    checkOutput("midrst_ar", {io_master_araddr, io_master_arid, io_master_arsize}, 0);
    nextCycle();
    raiseIfu($urandom);
    raiseLsu($urandom, 3'd2);
    applyStimulus(0, 0, 0, 0, {$urandom, $urandom}, 2'b00);
    drain();

    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 1) == 1) raiseIfu($urandom);
      if ($urandom_range(0, 1) == 1) raiseLsu($urandom, 3'($urandom_range(0, 3)));
      if (pend_ifu || pend_lsu) begin
        applyStimulus($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                      ($urandom_range(0, 7) == 0), {$urandom, $urandom}, 2'($urandom));
      end else begin
        @(negedge clk);
        checkOutput("idle_quiet", {ifu_arready, lsu_arready, io_master_arvalid}, 0);
        nextCycle();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
